// File: rtl/qeciphy_axis_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_axis_checker_if
// Purpose  : AXI-Stream RX bundle (data, valid, ready) that runs from the
//            QECIPHY receive path into the on-chip traffic checker.
// Signals  : RX_TDATA  [DATA_W] - received data word
//            RX_TVALID           - data word valid
//            RX_TREADY           - sink ready
// Modports : master - stream source (drives data/valid, sees ready)
//            slave  - stream sink   (sees data/valid, drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface qeciphy_axis_checker_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] RX_TDATA;
  logic              RX_TVALID;
  logic              RX_TREADY;

  modport master (output RX_TDATA, output RX_TVALID, input RX_TREADY);
  modport slave  (input RX_TDATA, input RX_TVALID, output RX_TREADY);
endinterface
`default_nettype wire

// File: rtl/qeciphy_axis_checker.sv
`default_nettype none
// ============================================================================
// Module   : qeciphy_axis_checker
// Purpose  : On-chip AXI-Stream traffic checker for the QECIPHY RX interface.
//            Regenerates the expected word sequence (counter or xorshift64),
//            compares it with every accepted beat and reports pass/fail,
//            a saturating error count and the index of the first mismatch.
// Ports    : ACLK           - clock
//            ARSTn          - asynchronous active-low reset
//            START          - one-cycle pulse that arms a run (IDLE or DONE)
//            rx (slave)     - RX_TDATA / RX_TVALID in, RX_TREADY out
//            BUSY           - run in progress
//            DONE           - SEQ_LEN beats consumed, sticky until next START
//            PASS           - valid with DONE: no mismatch and no overflow
//            ERR_CNT        - mismatch count, saturates at all-ones
//            BEAT_CNT       - beats accepted in this run
//            FIRST_ERR_IDX  - index of first mismatching beat, all-ones if none
//            OVERFLOW       - sticky, a beat was accepted while in DONE
// Revision : 1.0 - initial release
// ============================================================================
module qeciphy_axis_checker #(
  parameter int              DATA_W  = 64,
  parameter int              SEQ_LEN = 2048,
  parameter string           MODE    = "RANDOM",
  parameter logic [63:0]     SEED    = 64'h1,
  parameter int              ERR_W   = 16
) (
  input  wire                       ACLK,
  input  wire                       ARSTn,
  input  wire                       START,
  qeciphy_axis_checker_if.slave     rx,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      PASS,
  output logic [ERR_W-1:0]          ERR_CNT,
  output logic [31:0]               BEAT_CNT,
  output logic [31:0]               FIRST_ERR_IDX,
  output logic                      OVERFLOW
);

  localparam bit                c_COUNTER = (MODE == "COUNTER");
  localparam logic [DATA_W-1:0] c_INIT    = c_COUNTER ? '0 : SEED[DATA_W-1:0];
  localparam logic [31:0]       c_LAST    = 32'(SEQ_LEN - 1);
  localparam logic [ERR_W-1:0]  c_ERR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_tready;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_overflow;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [31:0]         r_beat_cnt;
  logic [31:0]         r_first_err;
  logic [DATA_W-1:0]   r_exp;

  logic                w_acc;
  logic                w_acc_run;
  logic                w_acc_done;
  logic                w_last;
  logic                w_start;
  logic                w_mis;
  logic [ERR_W-1:0]    w_err_nxt;
  logic [DATA_W-1:0]   w_exp_nxt;

  // Handshake qualification. START is only honoured outside RUN, which also
  // covers START coinciding with the final beat of a run.
  assign w_acc      = rx.RX_TVALID && r_tready;
  assign w_acc_run  = w_acc && (r_state == S_RUN);
  assign w_acc_done = w_acc && (r_state == S_DONE);
  assign w_last     = w_acc_run && (r_beat_cnt == c_LAST);
  assign w_start    = START && (r_state != S_RUN);
  assign w_mis      = w_acc_run && (rx.RX_TDATA != r_exp);
  assign w_err_nxt  = (w_mis && (r_err_cnt != c_ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;

  // Expected-word generator: advances on every accepted beat in RUN.
  generate
    if (c_COUNTER) begin : g_counter
      assign w_exp_nxt = r_exp + 1'b1;
    end else begin : g_random
      logic [DATA_W-1:0] w_s1;
      logic [DATA_W-1:0] w_s2;
      assign w_s1      = r_exp ^ (r_exp << 13);
      assign w_s2      = w_s1 ^ (w_s1 >> 7);
      assign w_exp_nxt = w_s2 ^ (w_s2 << 17);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (START)  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and compare datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_first_err <= '1;
      r_exp       <= c_INIT;
    end else begin
      // Ready/busy follow the next state so they are aligned with it.
      r_tready <= (w_state_nxt != S_IDLE);
      r_busy   <= (w_state_nxt == S_RUN);

      if (w_start) begin
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_overflow  <= 1'b0;
        r_err_cnt   <= '0;
        r_beat_cnt  <= '0;
        r_first_err <= '1;
        r_exp       <= c_INIT;
      end else if (w_acc_run) begin
        r_exp      <= w_exp_nxt;
        r_err_cnt  <= w_err_nxt;
        r_beat_cnt <= r_beat_cnt + 32'd1;
        if (w_mis && (r_first_err == '1)) begin
          r_first_err <= r_beat_cnt;
        end
        if (w_last) begin
          // Verdict includes the final beat's own compare result.
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == '0) && !r_overflow;
        end
      end else if (w_acc_done) begin
        // Drained beats after the run are never compared or counted.
        r_overflow <= 1'b1;
        r_pass     <= 1'b0;
      end
    end
  end

  assign rx.RX_TREADY  = r_tready;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign PASS          = r_pass;
  assign ERR_CNT       = r_err_cnt;
  assign BEAT_CNT      = r_beat_cnt;
  assign FIRST_ERR_IDX = r_first_err;
  assign OVERFLOW      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qeciphy_axis_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_qeciphy_axis_checker
// Purpose  : Directed self-checking bench for qeciphy_axis_checker. Three
//            instances share one stream source:
//              u_cnt - COUNTER, SEQ_LEN=2048, ERR_W=16
//              u_sml - COUNTER, SEQ_LEN=16,   ERR_W=4
//              u_rnd - RANDOM,  SEQ_LEN=128,  SEED=1
//            Each instance has its own START; only the armed one is targeted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qeciphy_axis_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        st_cnt, st_sml, st_rnd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qeciphy_axis_checker_if #(.DATA_W(64)) if_cnt ();
  qeciphy_axis_checker_if #(.DATA_W(64)) if_sml ();
  qeciphy_axis_checker_if #(.DATA_W(64)) if_rnd ();

  assign if_cnt.RX_TDATA  = r_tdata;
  assign if_cnt.RX_TVALID = r_tvalid;
  assign if_sml.RX_TDATA  = r_tdata;
  assign if_sml.RX_TVALID = r_tvalid;
  assign if_rnd.RX_TDATA  = r_tdata;
  assign if_rnd.RX_TVALID = r_tvalid;

  logic        cnt_busy, cnt_done, cnt_pass, cnt_ovf;
  logic [15:0] cnt_err;
  logic [31:0] cnt_beat, cnt_first;
  logic        sml_busy, sml_done, sml_pass, sml_ovf;
  logic [3:0]  sml_err;
  logic [31:0] sml_beat, sml_first;
  logic        rnd_busy, rnd_done, rnd_pass, rnd_ovf;
  logic [15:0] rnd_err;
  logic [31:0] rnd_beat, rnd_first;

  qeciphy_axis_checker #(.DATA_W(64), .SEQ_LEN(2048), .MODE("COUNTER"), .SEED(64'h1), .ERR_W(16)) u_cnt (
    .ACLK(clk), .ARSTn(rst_n), .START(st_cnt), .rx(if_cnt.slave),
    .BUSY(cnt_busy), .DONE(cnt_done), .PASS(cnt_pass), .ERR_CNT(cnt_err),
    .BEAT_CNT(cnt_beat), .FIRST_ERR_IDX(cnt_first), .OVERFLOW(cnt_ovf));

  qeciphy_axis_checker #(.DATA_W(64), .SEQ_LEN(16), .MODE("COUNTER"), .SEED(64'h1), .ERR_W(4)) u_sml (
    .ACLK(clk), .ARSTn(rst_n), .START(st_sml), .rx(if_sml.slave),
    .BUSY(sml_busy), .DONE(sml_done), .PASS(sml_pass), .ERR_CNT(sml_err),
    .BEAT_CNT(sml_beat), .FIRST_ERR_IDX(sml_first), .OVERFLOW(sml_ovf));

  qeciphy_axis_checker #(.DATA_W(64), .SEQ_LEN(128), .MODE("RANDOM"), .SEED(64'h1), .ERR_W(16)) u_rnd (
    .ACLK(clk), .ARSTn(rst_n), .START(st_rnd), .rx(if_rnd.slave),
    .BUSY(rnd_busy), .DONE(rnd_done), .PASS(rnd_pass), .ERR_CNT(rnd_err),
    .BEAT_CNT(rnd_beat), .FIRST_ERR_IDX(rnd_first), .OVERFLOW(rnd_ovf));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one beat; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [63:0] d);
    r_tvalid = 1'b1;
    r_tdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    r_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int which);
    r_tvalid = 1'b0;
    st_cnt   = (which == 0);
    st_sml   = (which == 1);
    st_rnd   = (which == 2);
    @(posedge clk);
    #1;
    st_cnt = 1'b0;
    st_sml = 1'b0;
    st_rnd = 1'b0;
  endtask

  function automatic logic [63:0] xs(input logic [63:0] v);
    logic [63:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  initial begin
    logic [63:0] x;
    logic [63:0] d;
    r_tvalid = 1'b0;
    r_tdata  = '0;
    st_cnt   = 1'b0;
    st_sml   = 1'b0;
    st_rnd   = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap(1);

    // Reset values
    chk("rst_tready", if_cnt.RX_TREADY, 1'b0);
    chk("rst_busy",   cnt_busy, 1'b0);
    chk("rst_done",   cnt_done, 1'b0);
    chk("rst_pass",   cnt_pass, 1'b0);
    chk("rst_err",    cnt_err, 16'd0);
    chk("rst_beat",   cnt_beat, 32'd0);
    chk("rst_first",  cnt_first, 32'hFFFF_FFFF);
    chk("rst_ovf",    cnt_ovf, 1'b0);

    // SEQ_LEN=16: 17 correct beats -> overflow on the 17th
    pulse(1);
    chk("sml_busy",   sml_busy, 1'b1);
    chk("sml_tready", if_sml.RX_TREADY, 1'b1);
    for (int i = 0; i < 16; i++) begin
      beat(64'(i));
      if (i == 14) chk("sml_done_early", sml_done, 1'b0);
    end
    chk("sml_done",   sml_done, 1'b1);
    chk("sml_pass",   sml_pass, 1'b1);
    chk("sml_beat",   sml_beat, 32'd16);
    chk("sml_busy_d", sml_busy, 1'b0);
    beat(64'd16);
    chk("sml_ovf",     sml_ovf, 1'b1);
    chk("sml_ovfpass", sml_pass, 1'b0);
    chk("sml_ovfbeat", sml_beat, 32'd16);
    gap(1);
    pulse(1);
    chk("sml_rs_beat", sml_beat, 32'd0);
    chk("sml_rs_ovf",  sml_ovf, 1'b0);
    chk("sml_rs_busy", sml_busy, 1'b1);
    chk("sml_rs_done", sml_done, 1'b0);

    // ERR_W=4: all beats wrong -> saturated count
    for (int i = 0; i < 16; i++) beat(64'(i) + 64'h1000);
    chk("sat_err",   sml_err, 4'hF);
    chk("sat_first", sml_first, 32'd0);
    chk("sat_pass",  sml_pass, 1'b0);
    chk("sat_done",  sml_done, 1'b1);
    gap(1);

    // RANDOM: bit 0 of beat 100 flipped
    pulse(2);
    x = 64'h1;
    for (int i = 0; i < 128; i++) begin
      d = x;
      if (i == 100) d[0] = ~d[0];
      beat(d);
      x = xs(x);
    end
    chk("rnd_done",  rnd_done, 1'b1);
    chk("rnd_pass",  rnd_pass, 1'b0);
    chk("rnd_err",   rnd_err, 16'd1);
    chk("rnd_first", rnd_first, 32'd100);
    chk("rnd_beat",  rnd_beat, 32'd128);
    gap(1);

    // COUNTER clean back-to-back run
    pulse(0);
    for (int i = 0; i < 2048; i++) begin
      beat(64'(i));
      if (i == 2046) chk("cnt_done_early", cnt_done, 1'b0);
    end
    chk("cnt_done",  cnt_done, 1'b1);
    chk("cnt_pass",  cnt_pass, 1'b1);
    chk("cnt_err",   cnt_err, 16'd0);
    chk("cnt_beat",  cnt_beat, 32'd2048);
    chk("cnt_first", cnt_first, 32'hFFFF_FFFF);
    gap(1);

    // Sparse valid, 50-cycle stall, START mid-run and on the final beat
    pulse(0);
    for (int i = 0; i < 2048; i++) begin
      if (i == 1000) gap(50);
      st_cnt = (i == 700) || (i == 2047);
      beat(64'(i));
      st_cnt = 1'b0;
      if (i != 2047) gap(2);
    end
    gap(1);
    chk("gap_done", cnt_done, 1'b1);
    chk("gap_busy", cnt_busy, 1'b0);
    chk("gap_pass", cnt_pass, 1'b1);
    chk("gap_beat", cnt_beat, 32'd2048);
    chk("gap_err",  cnt_err, 16'd0);

    // Reset mid-run at beat 500
    pulse(0);
    for (int i = 0; i < 500; i++) beat(64'(i) + ((i == 10) ? 64'd5 : 64'd0));
    r_tvalid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("ar_tready", if_cnt.RX_TREADY, 1'b0);
    chk("ar_busy",   cnt_busy, 1'b0);
    chk("ar_beat",   cnt_beat, 32'd0);
    chk("ar_err",    cnt_err, 16'd0);
    chk("ar_first",  cnt_first, 32'hFFFF_FFFF);
    gap(2);
    rst_n = 1'b1;
    gap(1);
    chk("ar_idle_tready", if_cnt.RX_TREADY, 1'b0);
    pulse(0);
    for (int i = 0; i < 2048; i++) beat(64'(i));
    chk("ar_run_done", cnt_done, 1'b1);
    chk("ar_run_pass", cnt_pass, 1'b1);
    chk("ar_run_beat", cnt_beat, 32'd2048);
    gap(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
